// File: rtl/conv_acc_pkg.sv
// Shared definitions for the ConvCoTM accelerator control path: scheduler state
// encoding, default coordinate width and the patch_size/stride field widths.
package conv_acc_pkg;

    localparam int CNT_W_DEF = 5;
    localparam int PSIZE_W   = 3;
    localparam int STRIDE_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_FIN   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/conv_axis_step.sv
// One axis of the patch walk: next position after a stride, and whether the
// following window would run past the image edge on this axis.
module conv_axis_step
    import conv_acc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0]    pos,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [PSIZE_W-1:0]  patch_size,
    input  logic [CNT_W-1:0]    dim,
    output logic [CNT_W-1:0]    next_pos,
    output logic                wrap
);

    // One extra bit so pos+stride+patch_size never wraps before the compare.
    logic [CNT_W:0] pos_end;

    assign pos_end  = {1'b0, pos} + (CNT_W+1)'(stride) + (CNT_W+1)'(patch_size);
    assign wrap     = pos_end > {1'b0, dim};
    assign next_pos = pos + CNT_W'(stride);

endmodule

// File: rtl/conv_patch_scheduler.sv
// Walks window top-left corners row-major over one image and streams them out
// under valid/ready. Optional stall counter behind CONV_SCHED_PERF_EN.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | waiting for start; config latched on start
//  ST_CHECK | one cycle of config validation, position reset
//  ST_RUN   | presenting patches, advancing on each accept
//  ST_FIN   | one-cycle done (with cfg_err if validation failed)
module conv_patch_scheduler
    import conv_acc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef CONV_SCHED_PERF_EN
    ,
    parameter int STALL_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    img_w,
    input  logic [CNT_W-1:0]    img_h,
    input  logic [PSIZE_W-1:0]  patch_size,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                patch_ready,
    output logic                patch_valid,
    output logic [CNT_W-1:0]    patch_x,
    output logic [CNT_W-1:0]    patch_y,
    output logic                patch_last,
    output logic                busy,
    output logic                done,
`ifdef CONV_SCHED_PERF_EN
    output logic [STALL_W-1:0]  stall_cnt,
`endif
    output logic                cfg_err
);

    sched_state_e state, state_nxt;

    logic [CNT_W-1:0]    w_q, h_q, x_q, y_q;
    logic [PSIZE_W-1:0]  ps_q;
    logic [STRIDE_W-1:0] st_q;
    logic                err_q;

    logic [CNT_W-1:0] x_next, y_next;
    logic             x_wrap, y_wrap;
    logic             cfg_bad, accept;

    conv_axis_step #(.CNT_W(CNT_W)) u_step_x (
        .pos        (x_q),
        .stride     (st_q),
        .patch_size (ps_q),
        .dim        (w_q),
        .next_pos   (x_next),
        .wrap       (x_wrap)
    );

    conv_axis_step #(.CNT_W(CNT_W)) u_step_y (
        .pos        (y_q),
        .stride     (st_q),
        .patch_size (ps_q),
        .dim        (h_q),
        .next_pos   (y_next),
        .wrap       (y_wrap)
    );

    assign cfg_bad = (ps_q == '0) || (st_q == '0) ||
                     (CNT_W'(ps_q) > w_q) || (CNT_W'(ps_q) > h_q);
    assign accept  = patch_valid && patch_ready;
    assign patch_x = x_q;
    assign patch_y = y_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        patch_valid = 1'b0;
        patch_last  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cfg_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                state_nxt = cfg_bad ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                busy        = 1'b1;
                patch_valid = 1'b1;
                patch_last  = x_wrap && y_wrap;
                if (patch_ready && x_wrap && y_wrap) state_nxt = ST_FIN;
            end
            ST_FIN: begin
                done      = 1'b1;
                cfg_err   = err_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q   <= '0;
            h_q   <= '0;
            ps_q  <= '0;
            st_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        w_q   <= img_w;
                        h_q   <= img_h;
                        ps_q  <= patch_size;
                        st_q  <= stride;
                        err_q <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    x_q   <= '0;
                    y_q   <= '0;
                    err_q <= cfg_bad;
                end
                ST_RUN: begin
                    if (accept) begin
                        if (x_wrap) begin
                            x_q <= '0;
                            y_q <= y_next;
                        end else begin
                            x_q <= x_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    // Cleared by an accepted start, left alone after done so software can read it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cnt <= '0;
        end else if (patch_valid && !patch_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// Scoreboard bench for conv_patch_scheduler: expected patch sequence queued at
// start, popped on each accept. Stall counter checked when CONV_SCHED_PERF_EN is set.
module tb_conv_patch_scheduler;
    import conv_acc_pkg::*;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] img_w, img_h;
    logic [2:0]       patch_size, stride;
    logic             patch_ready;
    logic             patch_valid;
    logic [CNT_W-1:0] patch_x, patch_y;
    logic             patch_last, busy, done, cfg_err;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    conv_patch_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .img_w       (img_w),
        .img_h       (img_h),
        .patch_size  (patch_size),
        .stride      (stride),
        .patch_ready (patch_ready),
        .patch_valid (patch_valid),
        .patch_x     (patch_x),
        .patch_y     (patch_y),
        .patch_last  (patch_last),
        .busy        (busy),
        .done        (done),
`ifdef CONV_SCHED_PERF_EN
        .stall_cnt   (stall_cnt),
`endif
        .cfg_err     (cfg_err)
    );

    typedef struct packed {
        logic             last;
        logic [CNT_W-1:0] y;
        logic [CNT_W-1:0] x;
    } patch_t;

    patch_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_valid"}, 32'(patch_valid), 0);
        check_val({tag, "_busy"},  32'(busy), 0);
        check_val({tag, "_done"},  32'(done), 0);
        check_val({tag, "_err"},   32'(cfg_err), 0);
        check_val({tag, "_last"},  32'(patch_last), 0);
        check_val({tag, "_x"},     32'(patch_x), 0);
        check_val({tag, "_y"},     32'(patch_y), 0);
`ifdef CONV_SCHED_PERF_EN
        check_val({tag, "_stall"}, 32'(stall_cnt), 0);
`endif
    endtask

    // Called right after a negedge; returns right after a negedge with the DUT in IDLE.
    task automatic run_scan(input int w, input int h, input int ps, input int st,
                            input bit rnd_ready, input bit repulse, input int abort_at);
        bit     exp_err, got_done, held, seen_valid, repulsed;
        int     exp_n, acc, cyc, last_acc_cyc, stalls;
        patch_t held_p, e, tmp;

        exp_err = (ps == 0) || (st == 0) || (ps > w) || (ps > h);
        exp_q.delete();
        exp_n = 0;
        if (!exp_err) begin
            for (int yy = 0; yy + ps <= h; yy += st)
                for (int xx = 0; xx + ps <= w; xx += st)
                    exp_q.push_back({1'b0, 5'(yy), 5'(xx)});
            tmp = exp_q[exp_q.size()-1];
            tmp.last = 1'b1;
            exp_q[exp_q.size()-1] = tmp;
            exp_n = ((w - ps) / st + 1) * ((h - ps) / st + 1);
        end

        got_done = 0; held = 0; seen_valid = 0; repulsed = 0;
        acc = 0; cyc = 0; last_acc_cyc = -10; stalls = 0;

        img_w = 5'(w); img_h = 5'(h); patch_size = 3'(ps); stride = 3'(st);
        start = 1'b1; patch_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scrambled inputs must not disturb the latched config.
        img_w = '0; img_h = '0; patch_size = 3'd7; stride = 3'd0;
        check_val("busy_in_check", 32'(busy), 1);
        check_val("valid_in_check", 32'(patch_valid), 0);

        while (!got_done && cyc < 4 * exp_n + 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (abort_at > 0 && acc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_idle_zero("abort");
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (held) check_val("valid_hold", 32'(patch_valid), 1);
            if (done) begin
                got_done = 1;
                check_val("cfg_err_at_done", 32'(cfg_err), 32'(exp_err));
                check_val("valid_at_done", 32'(patch_valid), 0);
                check_val("busy_at_done", 32'(busy), 0);
                if (!exp_err) check_val("done_latency", cyc, last_acc_cyc + 1);
            end else begin
                check_val("cfg_err_without_done", 32'(cfg_err), 0);
                if (patch_valid) begin
                    if (!seen_valid) check_val("first_valid_latency", cyc, 1);
                    seen_valid = 1;
                    if (held) begin
                        check_val("stall_x", 32'(patch_x), 32'(held_p.x));
                        check_val("stall_y", 32'(patch_y), 32'(held_p.y));
                        check_val("stall_last", 32'(patch_last), 32'(held_p.last));
                    end
                    patch_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (patch_ready) begin
                        acc++;
                        last_acc_cyc = cyc;
                        held = 0;
                        if (exp_q.size() == 0) begin
                            check_val("extra_patch", acc, exp_n);
                        end else begin
                            e = exp_q.pop_front();
                            check_val("patch_x", 32'(patch_x), 32'(e.x));
                            check_val("patch_y", 32'(patch_y), 32'(e.y));
                            check_val("patch_last", 32'(patch_last), 32'(e.last));
                        end
                        if (repulse && !repulsed && acc == 3) begin
                            start = 1'b1;
                            img_w = 5'd31; img_h = 5'd31; patch_size = 3'd1; stride = 3'd1;
                            repulsed = 1;
                        end
                    end else begin
                        stalls++;
                        held = 1;
                        held_p = {patch_last, patch_y, patch_x};
                    end
                end
            end
        end

        check_val("done_seen", 32'(got_done), 1);
        check_val("patch_count", acc, exp_n);
        check_val("queue_drained", exp_q.size(), 0);
        if (exp_err) check_val("no_valid_on_err", 32'(seen_valid), 0);
`ifdef CONV_SCHED_PERF_EN
        check_val("stall_cnt", 32'(stall_cnt), stalls);
`endif
        patch_ready = 1'b1;
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 0);
        check_val("idle_valid", 32'(patch_valid), 0);
        check_val("idle_done", 32'(done), 0);
`ifdef CONV_SCHED_PERF_EN
        check_val("stall_cnt_hold", 32'(stall_cnt), stalls);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; patch_ready = 1'b1;
        img_w = '0; img_h = '0; patch_size = '0; stride = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_scan(28, 28, 3, 1, 0, 0, 0);
        run_scan(8, 8, 4, 2, 0, 0, 0);
        run_scan(8, 8, 4, 2, 1, 0, 0);
        run_scan(8, 8, 3, 0, 0, 0, 0);
        run_scan(4, 4, 5, 2, 0, 0, 0);
        run_scan(8, 8, 0, 1, 0, 0, 0);
        run_scan(10, 10, 3, 1, 0, 1, 0);
        run_scan(10, 10, 3, 1, 0, 0, 10);
        run_scan(10, 10, 3, 1, 1, 0, 0);
        run_scan(5, 5, 5, 3, 0, 0, 0);
        run_scan(8, 8, 4, 2, 0, 0, 0);
        run_scan(13, 9, 3, 3, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
